// File: rtl/miriscv_rvfi_trace_buffer.sv
// Elastic FIFO between the miriscv RVFI retirement port and the trace consumer.
// Optional rvfi_order continuity checker enabled by `define MIRISCV_TRACE_ORDER_CHECK_EN.
module miriscv_rvfi_trace_buffer #(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       rvfi_valid_i,
  input  logic [63:0]                rvfi_order_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic                       rvfi_trap_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_pc_wdata_i,
  input  logic [4:0]                 rvfi_rd_addr_i,
  input  logic [31:0]                rvfi_rd_wdata_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [63:0]                trace_order_o,
  output logic [31:0]                trace_insn_o,
  output logic                       trace_trap_o,
  output logic [31:0]                trace_pc_rdata_o,
  output logic [31:0]                trace_pc_wdata_o,
  output logic [4:0]                 trace_rd_addr_o,
  output logic [31:0]                trace_rd_wdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       almost_full_o,
  output logic                       overflow_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  output logic                       order_err_o,
  output logic [63:0]                order_err_val_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PKT_W = 64 + 32 + 1 + 32 + 32 + 5 + 32;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PKT_W-1:0] pkt_in;
  logic [PKT_W-1:0] head_pkt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;

  assign full  = (count == FULL_CNT);
  assign pop   = trace_valid_o && trace_ready_i;
  assign push  = rvfi_valid_i && (!full || pop);

  assign pkt_in = {rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_pc_rdata_i,
                   rvfi_pc_wdata_i, rvfi_rd_addr_i, rvfi_rd_wdata_i};

  // Storage write: data path carries no reset; empty slots are masked on read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= pkt_in;
  end

  // Control: pointers, occupancy and drop accounting.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (rvfi_valid_i && !push) begin
        overflow_o <= 1'b1;
        drop_cnt_o <= sat_inc(drop_cnt_o);
      end
    end
  end

  assign count_o       = count;
  assign trace_valid_o = (count != '0);
  assign almost_full_o = (count >= AF_CNT);

  // Head entry is forced to zero while empty so reset clears the visible packet at once.
  assign head_pkt = trace_valid_o ? mem[rd_ptr] : '0;
  assign {trace_order_o, trace_insn_o, trace_trap_o, trace_pc_rdata_o,
          trace_pc_wdata_o, trace_rd_addr_o, trace_rd_wdata_o} = head_pkt;

`ifdef MIRISCV_TRACE_ORDER_CHECK_EN
  logic [63:0] exp_order;

  // Every retirement strobe is checked, including ones the FIFO drops.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      exp_order       <= '0;
      order_err_o     <= 1'b0;
      order_err_val_o <= '0;
    end else if (rvfi_valid_i) begin
      if ((rvfi_order_i != exp_order) && !order_err_o) begin
        order_err_o     <= 1'b1;
        order_err_val_o <= rvfi_order_i;
      end
      exp_order <= rvfi_order_i + 64'd1;
    end
  end
`else
  assign order_err_o     = 1'b0;
  assign order_err_val_o = '0;
`endif

endmodule

// File: tb/tb_miriscv_rvfi_trace_buffer.sv
// Directed self-checking bench for miriscv_rvfi_trace_buffer (DEPTH=8).
module tb_miriscv_rvfi_trace_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        arstn;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [63:0] trace_order;
  logic [31:0] trace_insn;
  logic        trace_trap;
  logic [31:0] trace_pc_rdata;
  logic [31:0] trace_pc_wdata;
  logic [4:0]  trace_rd_addr;
  logic [31:0] trace_rd_wdata;
  logic [3:0]  count;
  logic        almost_full;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        order_err;
  logic [63:0] order_err_val;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MIRISCV_TRACE_ORDER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  miriscv_rvfi_trace_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .rvfi_valid_i    (rvfi_valid),
    .rvfi_order_i    (rvfi_order),
    .rvfi_insn_i     (rvfi_insn),
    .rvfi_trap_i     (rvfi_trap),
    .rvfi_pc_rdata_i (rvfi_pc_rdata),
    .rvfi_pc_wdata_i (rvfi_pc_wdata),
    .rvfi_rd_addr_i  (rvfi_rd_addr),
    .rvfi_rd_wdata_i (rvfi_rd_wdata),
    .trace_valid_o   (trace_valid),
    .trace_ready_i   (trace_ready),
    .trace_order_o   (trace_order),
    .trace_insn_o    (trace_insn),
    .trace_trap_o    (trace_trap),
    .trace_pc_rdata_o(trace_pc_rdata),
    .trace_pc_wdata_o(trace_pc_wdata),
    .trace_rd_addr_o (trace_rd_addr),
    .trace_rd_wdata_o(trace_rd_wdata),
    .count_o         (count),
    .almost_full_o   (almost_full),
    .overflow_o      (overflow),
    .drop_cnt_o      (drop_cnt),
    .order_err_o     (order_err),
    .order_err_val_o (order_err_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [63:0] o);
    return {16'hA5A5, o[15:0]};
  endfunction

  function automatic logic [31:0] pc_of(input logic [63:0] o);
    return 32'h8000_0000 + {o[29:0], 2'b00};
  endfunction

  // Drive a retirement whose side fields are all derived from its order.
  task automatic drive(input logic v, input logic [63:0] o);
    rvfi_valid    = v;
    rvfi_order    = o;
    rvfi_insn     = insn_of(o);
    rvfi_trap     = o[0];
    rvfi_pc_rdata = pc_of(o);
    rvfi_pc_wdata = pc_of(o) + 32'd4;
    rvfi_rd_addr  = o[4:0];
    rvfi_rd_wdata = ~o[31:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 64'd0);
    trace_ready = 1'b0;
    arstn = 1'b0;
    #2;
    arstn = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [63:0] o);
    check({tag, "_valid"}, {63'd0, trace_valid}, 64'd1);
    check({tag, "_order"}, trace_order, o);
    check({tag, "_insn"}, {32'd0, trace_insn}, {32'd0, insn_of(o)});
    check({tag, "_trap"}, {63'd0, trace_trap}, {63'd0, o[0]});
    check({tag, "_pcr"}, {32'd0, trace_pc_rdata}, {32'd0, pc_of(o)});
    check({tag, "_pcw"}, {32'd0, trace_pc_wdata}, {32'd0, pc_of(o) + 32'd4});
    check({tag, "_rd"}, {59'd0, trace_rd_addr}, {59'd0, o[4:0]});
    check({tag, "_rdw"}, {32'd0, trace_rd_wdata}, {32'd0, ~o[31:0]});
  endtask

  initial begin
    arstn = 1'b0;
    trace_ready = 1'b0;
    drive(1'b0, 64'd0);
    #1;
    check("rst_valid", {63'd0, trace_valid}, 64'd0);
    check("rst_count", {60'd0, count}, 64'd0);
    check("rst_af", {63'd0, almost_full}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_drop", {48'd0, drop_cnt}, 64'd0);
    check("rst_oerr", {63'd0, order_err}, 64'd0);
    check("rst_oval", order_err_val, 64'd0);
    check("rst_order", trace_order, 64'd0);
    check("rst_rdw", {32'd0, trace_rd_wdata}, 64'd0);
    step();
    arstn = 1'b1;

    // Streaming with consumer always ready
    trace_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'(i));
      step();
      check_head("stream", 64'(i));
      check("stream_count", {60'd0, count}, 64'd1);
    end
    drive(1'b0, 64'd0);
    step();
    check("stream_empty", {63'd0, trace_valid}, 64'd0);
    check("stream_count0", {60'd0, count}, 64'd0);
    check("stream_ovf", {63'd0, overflow}, 64'd0);
    check("stream_oerr", {63'd0, order_err}, 64'd0);

    // Fill with back-pressure, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'(i));
      step();
      check("fill_count", {60'd0, count}, 64'(i + 1));
      check("fill_af", {63'd0, almost_full}, (i + 1 >= DEPTH - 1) ? 64'd1 : 64'd0);
    end
    check("fill_ovf0", {63'd0, overflow}, 64'd0);
    drive(1'b1, 64'd100);
    step();
    check("drop_count", {60'd0, count}, 64'd8);
    check("drop_ovf", {63'd0, overflow}, 64'd1);
    check("drop_cnt1", {48'd0, drop_cnt}, 64'd1);
    check_head("drop_head", 64'd0);

    // Full with simultaneous push and pop
    drive(1'b1, 64'd8);
    trace_ready = 1'b1;
    step();
    drive(1'b0, 64'd0);
    check("fpp_count", {60'd0, count}, 64'd8);
    check("fpp_drop", {48'd0, drop_cnt}, 64'd1);
    for (int k = 1; k <= 8; k++) begin
      check("drain_order", trace_order, 64'(k));
      step();
    end
    check("drain_empty", {63'd0, trace_valid}, 64'd0);
    check("drain_ovf", {63'd0, overflow}, 64'd1);

    // Hold head under back-pressure
    do_reset();
    drive(1'b1, 64'd13);
    step();
    drive(1'b0, 64'd0);
    for (int k = 0; k < 5; k++) begin
      check_head("hold", 64'd13);
      step();
    end
    trace_ready = 1'b1;
    step();
    check("rel_valid", {63'd0, trace_valid}, 64'd0);
    check("rel_count", {60'd0, count}, 64'd0);

    // Order continuity
    do_reset();
    trace_ready = 1'b1;
    drive(1'b1, 64'd0); step();
    drive(1'b1, 64'd1); step();
    drive(1'b1, 64'd2); step();
    check("ord_ok", {63'd0, order_err}, 64'd0);
    drive(1'b1, 64'd5); step();
    check("ord_err", {63'd0, order_err}, {63'd0, CHK_EN});
    check("ord_val", order_err_val, CHK_EN ? 64'd5 : 64'd0);
    drive(1'b1, 64'd6); step();
    drive(1'b1, 64'd9); step();
    check("ord_err2", {63'd0, order_err}, {63'd0, CHK_EN});
    check("ord_val2", order_err_val, CHK_EN ? 64'd5 : 64'd0);
    drive(1'b0, 64'd0); step();

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(i));
      step();
    end
    drive(1'b0, 64'd0);
    check("ar_count4", {60'd0, count}, 64'd4);
    #2;
    arstn = 1'b0;
    #1;
    check("ar_valid", {63'd0, trace_valid}, 64'd0);
    check("ar_count", {60'd0, count}, 64'd0);
    check("ar_order", trace_order, 64'd0);
    check("ar_insn", {32'd0, trace_insn}, 64'd0);
    check("ar_af", {63'd0, almost_full}, 64'd0);
    arstn = 1'b1;
    drive(1'b1, 64'd0);
    step();
    drive(1'b0, 64'd0);
    check("ar_push_count", {60'd0, count}, 64'd1);
    check_head("ar_head", 64'd0);
    step();
    check("ar_hold_count", {60'd0, count}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/miriscv_rvfi_trace_buffer.md
# miriscv_rvfi_trace_buffer

Elastic buffer between the miriscv core's RVFI retirement port and the testbench RVFI monitor/scoreboard. Captures every retired-instruction packet into a FIFO and drains it through a valid/ready interface, so the consumer can apply back-pressure without losing retirements. Reports overflow, dropped-packet count and, optionally, `rvfi_order` continuity errors.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `DROP_CNT_W`, 16: width of the saturating drop counter.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `arstn_i`  in  1  reset; asynchronous and active-low.
- `rvfi_valid_i`  in  1  retirement strobe from core.
- `rvfi_order_i`  in  64  retirement index.
- `rvfi_insn_i`  in  32  instruction word.
- `rvfi_trap_i`  in  1  trap flag.
- `rvfi_pc_rdata_i`  in  32  PC of retired instruction.
- `rvfi_pc_wdata_i`  in  32  next PC.
- `rvfi_rd_addr_i`  in  5  destination register.
- `rvfi_rd_wdata_i`  in  32  destination write data.
- `trace_valid_o`  out  1  head entry available.
- `trace_ready_i`  in  1  consumer accepts head.
- `trace_order_o`, `trace_insn_o`, `trace_trap_o`, `trace_pc_rdata_o`, `trace_pc_wdata_o`, `trace_rd_addr_o`, `trace_rd_wdata_o`  out  64/32/1/32/32/5/32  head packet fields.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.
- `almost_full_o`  out  1  `count_o >= DEPTH-1`.
- `overflow_o`  out  1  sticky: a packet was dropped.
- `drop_cnt_o`  out  DROP_CNT_W  dropped packets, saturating.
- `order_err_o`  out  1  sticky order discontinuity.
- `order_err_val_o`  out  64  first offending `rvfi_order_i`.

## Operation
- Storage: DEPTH-entry circular FIFO, separate write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; occupancy counter 0..DEPTH.
- Push: `rvfi_valid_i && (!full || pop)`; the packet is written at the write pointer.
- Pop: `trace_valid_o && trace_ready_i`; advances the read pointer.
- Full with simultaneous pop: the push is accepted and the count is unchanged.
- Full without pop: the push is dropped. `overflow_o` sets and stays set. `drop_cnt_o` increments and saturates at all-ones.
- Empty with push: the push is written. `trace_valid_o` rises the next cycle; the FIFO is not bypassed.
- Empty with pop: cannot occur, because `trace_valid_o`=0 when empty.
- `trace_*_o` are driven from the head entry. They hold stable while `trace_valid_o && !trace_ready_i`.
- `rvfi_*` inputs other than `rvfi_valid_i` are ignored when `rvfi_valid_i`=0.

## Timing
- Latency: a push at edge N gives `trace_valid_o`=1 after edge N with that packet on `trace_*_o`.
- Throughput: one push and one pop per cycle.
- `count_o`, `almost_full_o` and `trace_valid_o` are registered and reflect state after the last edge.
- Reset values: `trace_valid_o`=0, `count_o`=0, `almost_full_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `order_err_o`=0, `order_err_val_o`=0, all `trace_*_o` data=0, pointers=0, expected order=0.
- Reset asserted mid-operation discards all entries immediately (asynchronously). The first edge after deassertion behaves as from the empty state.

## Configuration
- Macro `MIRISCV_TRACE_ORDER_CHECK_EN`.
- Defined:
  - The expected-order register starts at 0.
  - On every `rvfi_valid_i`, dropped or not, it is compared with `rvfi_order_i`.
  - On a mismatch while `order_err_o`=0: `order_err_o` sets and `order_err_val_o` captures `rvfi_order_i`.
  - The expected order then becomes `rvfi_order_i+1` (64-bit wrap).
- Undefined: the checker logic is absent, and `order_err_o`/`order_err_val_o` are tied to 0.

## Test plan
- DEPTH=8, `trace_ready_i`=1, 20 back-to-back retirements with order 0..19 -> all 20 emerge in order, each 1 cycle later; `count_o` ≤1; `overflow_o`=0.
- `trace_ready_i`=0, 8 pushes -> `count_o`=8, `almost_full_o`=1 from 7 entries. A 9th push -> dropped, `overflow_o`=1, `drop_cnt_o`=1, head still order 0.
- Full FIFO, simultaneous push (order 8) and pop -> `count_o` stays 8, `drop_cnt_o` unchanged; order 8 is drained last.
- Hold `trace_ready_i`=0 for 5 cycles with 1 entry -> `trace_*_o` stable. Release -> accepted in 1 cycle, `trace_valid_o`=0 after.
- Macro defined, orders 0,1,2,5,6 -> `order_err_o`=1 after order 5, `order_err_val_o`=5. A later gap (6→9) leaves `order_err_val_o`=5. Macro undefined -> `order_err_o`=0.
- 4 entries buffered, pulse `arstn_i` low mid-cycle -> outputs zero immediately; after release, a push of order 0 appears as the sole entry.
